// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tristate_bus_arbiter
//  Description : Registered N_CH:1 arbiter onto a shared internal tristate
//                bus. A winner index (round-robin or fixed select) is decoded
//                to a one-hot grant that enables exactly one channel's
//                tristate driver; the bus is captured into bus_out on each
//                beat. Bursts are bounded to MAX_BURST beats per grant.
//  Ports       : clk        - clock, rising-edge active
//                rst        - synchronous active-high reset
//                mode_rr    - 1 = round-robin, 0 = fixed select via sel
//                sel        - channel index used in fixed mode
//                req        - per-channel level request
//                data_in    - channel i data at [i*DATA_W +: DATA_W]
//                grant_oh   - one-hot grant / tristate enables
//                grant_idx  - binary index of current grantee
//                bus_out    - registered bus data
//                bus_valid  - bus_out holds a beat this cycle
//                ack        - one-hot pulse for the channel on bus_out
//  Revision    : 1.0 - initial release
// ============================================================================
module tristate_bus_arbiter #(
    parameter int N_CH      = 8,
    parameter int DATA_W    = 8,
    parameter int SEL_W     = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode_rr,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH-1:0]        req,
    input  logic [N_CH*DATA_W-1:0] data_in,
    output logic [N_CH-1:0]        grant_oh,
    output logic [SEL_W-1:0]       grant_idx,
    output logic [DATA_W-1:0]      bus_out,
    output logic                   bus_valid,
    output logic [N_CH-1:0]        ack
);

    localparam int                 C_IDX_SPAN = 1 << SEL_W;
    localparam int                 C_CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [C_CNT_W-1:0] C_PENULT   = C_CNT_W'(MAX_BURST - 1);
    localparam logic [SEL_W-1:0]   C_LAST_CH  = SEL_W'(N_CH - 1);
    localparam logic [SEL_W:0]     C_NCH_EXT  = (SEL_W + 1)'(N_CH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]         r_state;
    logic [N_CH-1:0]    r_grant_oh;
    logic [SEL_W-1:0]   r_grant_idx;
    logic [DATA_W-1:0]  r_bus_out;
    logic               r_bus_valid;
    logic [N_CH-1:0]    r_ack;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [C_CNT_W-1:0] r_beat_cnt;
    // Set when a grant ends so the following IDLE cycle is a dead cycle
    // that performs no arbitration.
    logic               r_cool;

    // Requests padded to the full index span; padding bits are zero, so a
    // select index >= N_CH naturally finds no request.
    logic [C_IDX_SPAN-1:0] w_req_ext;
    assign w_req_ext = C_IDX_SPAN'(req);

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    logic             w_win_found;
    logic [SEL_W-1:0] w_win_idx;
    logic [SEL_W:0]   w_cand;

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        if (mode_rr) begin
            for (int k = 0; k < N_CH; k++) begin
                // (rr_ptr + k) mod N_CH; sum stays below 2*N_CH, one
                // conditional subtract is enough for non-power-of-2 N_CH.
                w_cand = {1'b0, r_rr_ptr} + (SEL_W + 1)'(k);
                if (w_cand >= C_NCH_EXT) begin
                    w_cand = w_cand - C_NCH_EXT;
                end
                if (!w_win_found && w_req_ext[w_cand[SEL_W-1:0]]) begin
                    w_win_found = 1'b1;
                    w_win_idx   = w_cand[SEL_W-1:0];
                end
            end
        end else if (w_req_ext[sel]) begin
            w_win_found = 1'b1;
            w_win_idx   = sel;
        end
    end

    // ------------------------------------------------------------------
    // Internal tristate bus: only the granted channel drives it
    // ------------------------------------------------------------------
    tri [DATA_W-1:0] w_bus;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_drv
            assign w_bus = r_grant_oh[i] ? data_in[i*DATA_W +: DATA_W]
                                         : {DATA_W{1'bz}};
        end
    endgenerate

    logic             w_req_g;
    logic [SEL_W-1:0] w_next_ptr;

    assign w_req_g    = w_req_ext[r_grant_idx];
    assign w_next_ptr = (r_grant_idx == C_LAST_CH) ? '0
                                                   : r_grant_idx + SEL_W'(1);

    // ------------------------------------------------------------------
    // State machine and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant_oh  <= '0;
            r_grant_idx <= '0;
            r_bus_out   <= '0;
            r_bus_valid <= 1'b0;
            r_ack       <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_cool      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bus_valid <= 1'b0;
                    r_ack       <= '0;
                    if (r_cool) begin
                        r_cool <= 1'b0;
                    end else if (w_win_found) begin
                        r_state     <= S_GRANT;
                        r_grant_oh  <= N_CH'(1) << w_win_idx;
                        r_grant_idx <= w_win_idx;
                        r_beat_cnt  <= '0;
                    end
                end
                S_GRANT: begin
                    // bus_out only loads on a beat, so an undriven bus is
                    // never captured.
                    if (w_req_g) begin
                        r_bus_out   <= w_bus;
                        r_bus_valid <= 1'b1;
                        r_ack       <= r_grant_oh;
                        r_beat_cnt  <= r_beat_cnt + C_CNT_W'(1);
                    end else begin
                        r_bus_valid <= 1'b0;
                        r_ack       <= '0;
                    end
                    if (!w_req_g || (r_beat_cnt == C_PENULT)) begin
                        r_state    <= S_IDLE;
                        r_grant_oh <= '0;
                        r_rr_ptr   <= w_next_ptr;
                        r_cool     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_oh  = r_grant_oh;
    assign grant_idx = r_grant_idx;
    assign bus_out   = r_bus_out;
    assign bus_valid = r_bus_valid;
    assign ack       = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tristate_bus_arbiter
//  Description : Self-checking bench for tristate_bus_arbiter: directed
//                scenarios plus randomized traffic against a cycle model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tristate_bus_arbiter;

    localparam int N_CH      = 8;
    localparam int DATA_W    = 8;
    localparam int SEL_W     = 3;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   mode_rr;
    logic [SEL_W-1:0]       sel;
    logic [N_CH-1:0]        req;
    logic [N_CH*DATA_W-1:0] data_in;
    logic [N_CH-1:0]        grant_oh;
    logic [SEL_W-1:0]       grant_idx;
    logic [DATA_W-1:0]      bus_out;
    logic                   bus_valid;
    logic [N_CH-1:0]        ack;

    tristate_bus_arbiter #(
        .N_CH(N_CH), .DATA_W(DATA_W), .SEL_W(SEL_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .mode_rr(mode_rr), .sel(sel), .req(req),
        .data_in(data_in), .grant_oh(grant_oh), .grant_idx(grant_idx),
        .bus_out(bus_out), .bus_valid(bus_valid), .ack(ack)
    );

    // Six-channel instance for the non-power-of-2 select range.
    logic        rst6;
    logic        mode6;
    logic [2:0]  sel6;
    logic [5:0]  req6;
    logic [47:0] data6;
    logic [5:0]  grant6;
    logic [2:0]  gidx6;
    logic [7:0]  bus6;
    logic        valid6;
    logic [5:0]  ack6;

    tristate_bus_arbiter #(
        .N_CH(6), .DATA_W(8), .SEL_W(3), .MAX_BURST(4)
    ) dut6 (
        .clk(clk), .rst(rst6), .mode_rr(mode6), .sel(sel6), .req(req6),
        .data_in(data6), .grant_oh(grant6), .grant_idx(gidx6),
        .bus_out(bus6), .bus_valid(valid6), .ack(ack6)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: grantee as an integer (-1 = none), beats taken,
    // round-robin start channel and a dead-cycle flag.
    // ------------------------------------------------------------------
    int                m_g = -1;
    int                m_beats = 0;
    int                m_ptr = 0;
    bit                m_cool = 0;
    logic [N_CH-1:0]   m_oh = '0;
    logic [SEL_W-1:0]  m_idx = '0;
    logic [DATA_W-1:0] m_bus = '0;
    logic              m_valid = 1'b0;
    logic [N_CH-1:0]   m_ack = '0;

    task automatic model_edge();
        int w;
        if (rst) begin
            m_g = -1; m_beats = 0; m_ptr = 0; m_cool = 0;
            m_oh = '0; m_idx = '0; m_bus = '0; m_valid = 1'b0; m_ack = '0;
        end else if (m_g < 0) begin
            m_valid = 1'b0;
            m_ack   = '0;
            if (m_cool) begin
                m_cool = 0;
            end else begin
                w = -1;
                if (mode_rr) begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (w < 0 && req[(m_ptr + k) % N_CH]) w = (m_ptr + k) % N_CH;
                    end
                end else if (int'(sel) < N_CH && req[sel]) begin
                    w = int'(sel);
                end
                if (w >= 0) begin
                    m_g = w; m_beats = 0;
                    m_oh = '0; m_oh[w] = 1'b1;
                    m_idx = SEL_W'(w);
                end
            end
        end else begin
            if (req[m_g]) begin
                m_bus   = data_in[m_g*DATA_W +: DATA_W];
                m_valid = 1'b1;
                m_ack   = m_oh;
                m_beats++;
            end else begin
                m_valid = 1'b0;
                m_ack   = '0;
            end
            if (!req[m_g] || m_beats == MAX_BURST) begin
                m_ptr  = (m_g + 1) % N_CH;
                m_g    = -1;
                m_oh   = '0;
                m_cool = 1;
            end
        end
    endtask

    // One clock: model follows the edge, outputs settle 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] v);
        data_in[ch*DATA_W +: DATA_W] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; mode_rr = 1'b1; sel = '0;
        data_in = {$urandom, $urandom};
        tick();
        tick();
        checks++; if (grant_oh !== 8'h00) begin errors++; $display("FAIL reset_grant: got %h want 00", grant_oh); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_valid); end
        checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus: got %h want 00", bus_out); end
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL reset_ack: got %h want 00", ack); end
        checks++; if (grant_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
        rst = 1'b0; req = '0;
    endtask

    task automatic test_rr_burst();
        do_reset();
        mode_rr = 1'b1;
        set_ch(3, 8'hA5);
        req = 8'h08;
        tick();
        checks++; if (grant_oh !== 8'h08) begin errors++; $display("FAIL burst_grant: got %h want 08", grant_oh); end
        checks++; if (grant_idx !== 3'd3) begin errors++; $display("FAIL burst_idx: got %0d want 3", grant_idx); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL burst_lat: valid got %b want 0", bus_valid); end
        for (int b = 0; b < MAX_BURST; b++) begin
            tick();
            checks++; if (bus_valid !== 1'b1 || bus_out !== 8'hA5 || ack !== 8'h08) begin
                errors++; $display("FAIL burst_beat%0d: valid=%b bus=%h ack=%h want 1 a5 08", b, bus_valid, bus_out, ack);
            end
            checks++; if (grant_oh !== ((b == MAX_BURST - 1) ? 8'h00 : 8'h08)) begin
                errors++; $display("FAIL burst_hold%0d: grant got %h", b, grant_oh);
            end
        end
        tick();
        checks++; if (bus_valid !== 1'b0 || ack !== 8'h00 || grant_oh !== 8'h00) begin
            errors++; $display("FAIL burst_dead: valid=%b ack=%h grant=%h want 0 00 00", bus_valid, ack, grant_oh);
        end
        tick();
        checks++; if (grant_oh !== 8'h08) begin errors++; $display("FAIL burst_regrant: got %h want 08", grant_oh); end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_rr_wrap();
        logic [7:0] seq[$];
        logic [7:0] prev;
        logic [7:0] exp_seq [3];
        exp_seq = '{8'h01, 8'h80, 8'h01};
        prev = '0;
        do_reset();
        mode_rr = 1'b1;
        req = 8'h81;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (grant_oh != 8'h00 && prev == 8'h00) seq.push_back(grant_oh);
            prev = grant_oh;
        end
        checks++; if (seq.size() < 3) begin errors++; $display("FAIL wrap_count: got %0d grants want >=3", seq.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (seq.size() <= i || seq[i] !== exp_seq[i]) begin
                errors++; $display("FAIL wrap_seq%0d: got %h want %h", i, (seq.size() > i) ? seq[i] : 8'hxx, exp_seq[i]);
            end
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_early_release();
        int acks;
        acks = 0;
        do_reset();
        mode_rr = 1'b1;
        set_ch(2, 8'h3C);
        req = 8'h04;
        tick();
        checks++; if (grant_oh !== 8'h04) begin errors++; $display("FAIL early_grant: got %h want 04", grant_oh); end
        for (int b = 0; b < 2; b++) begin
            tick();
            if (ack === 8'h04) acks++;
            checks++; if (bus_out !== 8'h3C) begin errors++; $display("FAIL early_data%0d: got %h want 3c", b, bus_out); end
        end
        req = 8'h00;
        tick();
        checks++; if (bus_valid !== 1'b0 || ack !== 8'h00 || grant_oh !== 8'h00) begin
            errors++; $display("FAIL early_end: valid=%b ack=%h grant=%h want 0 00 00", bus_valid, ack, grant_oh);
        end
        checks++; if (acks != 2) begin errors++; $display("FAIL early_acks: got %0d want 2", acks); end
        tick();
        req = 8'h09;
        tick();
        checks++; if (grant_oh !== 8'h08) begin errors++; $display("FAIL early_ptr: got %h want 08", grant_oh); end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_fixed();
        int  grants;
        bit  found;
        logic [7:0] prev;
        grants = 0; found = 0; prev = '0;
        do_reset();
        mode_rr = 1'b0; sel = 3'd5; req = 8'hFF;
        for (int c = 0; c < 14; c++) begin
            data_in = {$urandom, $urandom};
            tick();
            checks++; if ((grant_oh !== 8'h00 && grant_oh !== 8'h20) || (ack !== 8'h00 && ack !== 8'h20)) begin
                errors++; $display("FAIL fixed_only5: grant=%h ack=%h", grant_oh, ack);
            end
            if (grant_oh == 8'h20 && prev == 8'h00) grants++;
            prev = grant_oh;
        end
        checks++; if (grants < 2) begin errors++; $display("FAIL fixed_repeat: got %0d grants want >=2", grants); end
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (grant_oh === 8'h20 && bus_valid === 1'b0) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL fixed_wait: fresh ch5 grant not seen within 10 cycles"); end
        tick();
        sel = 3'd1;
        for (int b = 1; b < MAX_BURST; b++) begin
            tick();
            checks++; if (ack !== 8'h20) begin errors++; $display("FAIL fixed_switch_ack%0d: got %h want 20", b, ack); end
        end
        checks++; if (grant_oh !== 8'h00) begin errors++; $display("FAIL fixed_switch_end: got %h want 00", grant_oh); end
        tick();
        tick();
        checks++; if (grant_oh !== 8'h02) begin errors++; $display("FAIL fixed_switch_next: got %h want 02", grant_oh); end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        mode_rr = 1'b1;
        req = 8'h10;
        tick(); tick();
        req = 8'h00;
        tick(); tick();
        req = 8'h20;
        tick();
        checks++; if (grant_oh !== 8'h20) begin errors++; $display("FAIL rstmid_grant: got %h want 20", grant_oh); end
        tick(); tick();
        rst = 1'b1;
        req = 8'h21;
        tick();
        checks++; if (grant_oh !== 8'h00 || bus_valid !== 1'b0 || ack !== 8'h00 || bus_out !== 8'h00 || grant_idx !== 3'd0) begin
            errors++; $display("FAIL rstmid_zero: grant=%h valid=%b ack=%h bus=%h idx=%0d want all zero", grant_oh, bus_valid, ack, bus_out, grant_idx);
        end
        rst = 1'b0;
        tick();
        checks++; if (grant_oh !== 8'h01) begin errors++; $display("FAIL rstmid_ptr: got %h want 01", grant_oh); end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) mode_rr = $urandom_range(0, 1);
            sel = SEL_W'($urandom_range(0, N_CH - 1));
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            end
            data_in = {$urandom, $urandom};
            tick();
            checks++; if (grant_oh !== m_oh || grant_idx !== m_idx || bus_valid !== m_valid || ack !== m_ack || bus_out !== m_bus) begin
                errors++;
                $display("FAIL rand_c%0d: grant=%h idx=%0d valid=%b ack=%h bus=%h want %h %0d %b %h %h",
                         c, grant_oh, grant_idx, bus_valid, ack, bus_out, m_oh, m_idx, m_valid, m_ack, m_bus);
            end
        end
        rst = 1'b0;
        req = '0;
        tick(); tick();
    endtask

    task automatic test_nch6();
        rst6 = 1'b1; mode6 = 1'b0; sel6 = 3'd7; req6 = 6'h3F;
        data6 = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        rst6 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sel6 = (c < 3) ? 3'd7 : 3'd6;
            tick();
            checks++; if (grant6 !== 6'h00 || valid6 !== 1'b0) begin
                errors++; $display("FAIL n6_nogrant%0d: grant=%h valid=%b want 00 0", c, grant6, valid6);
            end
        end
        sel6 = 3'd5;
        tick();
        checks++; if (grant6 !== 6'h20 || gidx6 !== 3'd5) begin
            errors++; $display("FAIL n6_grant5: grant=%h idx=%0d want 20 5", grant6, gidx6);
        end
        tick();
        checks++; if (bus6 !== 8'h66 || ack6 !== 6'h20) begin
            errors++; $display("FAIL n6_beat: bus=%h ack=%h want 66 20", bus6, ack6);
        end
    endtask

    initial begin
        rst = 1'b1; mode_rr = 1'b1; sel = '0; req = '0; data_in = '0;
        rst6 = 1'b1; mode6 = 1'b0; sel6 = '0; req6 = '0; data6 = '0;
        test_reset();
        test_rr_burst();
        test_rr_wrap();
        test_early_release();
        test_fixed();
        test_reset_mid_burst();
        test_random();
        test_nch6();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Parametrised, registered successor of the decoder-plus-tristate 8:1 mux.
- Arbitrates N_CH requesting channels of DATA_W-bit data onto one shared internal tristate bus.
- Select index → one-hot decoder → per-channel tristate drivers.
- Supports fixed-select and round-robin modes, bounded bursts, per-beat acknowledge.
- Sits between channel producers and a single downstream consumer.

Parameters:
- N_CH, 8, number of input channels (2..64; need not be a power of 2).
- DATA_W, 8, data width per channel.
- SEL_W, 3, select index width; must equal clog2(N_CH).
- MAX_BURST, 4, maximum beats per grant (≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode_rr  input  1  1 = round-robin arbitration, 0 = fixed select via sel.
- sel  input  SEL_W  channel index used when mode_rr=0.
- req  input  N_CH  per-channel request; level, held while channel has data.
- data_in  input  N_CH*DATA_W  channel i data at bits [i*DATA_W +: DATA_W].
- grant_oh  output  N_CH  one-hot grant (decoder output); drives tristate enables.
- grant_idx  output  SEL_W  binary index of current grantee.
- bus_out  output  DATA_W  registered bus data.
- bus_valid  output  1  bus_out holds a beat this cycle.
- ack  output  N_CH  one-hot pulse; channel whose beat is on bus_out this cycle.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; grant_oh=0, grant_idx=0, bus_out=0, bus_valid=0, ack=0, rr_ptr=0, beat_cnt=0. Reset mid-burst aborts the burst; no ack/valid in the cycle after.
- FSM states: IDLE, GRANT.
- IDLE → GRANT on the edge where a winner exists:
  - mode_rr=1: winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, … modulo N_CH.
  - mode_rr=0: winner = sel if sel<N_CH and req[sel]=1. sel≥N_CH → no grant, stay IDLE.
  - On entry: grant_oh=1<<winner, grant_idx=winner, beat_cnt=0.
- GRANT, each edge with req[g]=1 (g = grantee):
  - bus_out ← value on internal tristate bus (= data_in[g]), bus_valid←1, ack←1<<g, beat_cnt+1.
  - Beat counting is gated by req[g] only, never by bus_valid.
- GRANT, edge with req[g]=0: no beat; bus_valid←0, ack←0. Grant ends.
- Grant ends on the earlier of:
  - req[g]=0 at an edge, or
  - the edge that completes beat MAX_BURST.
- At grant end: state←IDLE, grant_oh←0, rr_ptr←(g+1) mod N_CH (wraps at N_CH-1→0). rr_ptr is updated in both modes.
- IDLE always lasts at least one cycle between grants (dead cycle); bus_valid=0 on the edge after the last beat unless a new beat occurs (it cannot).
- Latency: req rising in IDLE at cycle t → grant_oh at t+1 → first bus_valid/ack at t+2.
- Tristate rules:
  - Internal bus driven only by channel with grant_oh bit set; otherwise high-Z.
  - bus_out loads only on a beat, so Z/X never propagate; bus_out holds last value when bus_valid=0.
- sel and mode_rr changes during GRANT are ignored until the next IDLE arbitration.
- grant_oh is always zero or one-hot; ack is always zero or equal to the grant_oh of the previous cycle.
- data_in of non-granted channels has no effect on any output.

Test Plan (N_CH=8, DATA_W=8, MAX_BURST=4 unless noted):
- Reset: apply rst for 2 cycles with all req=0xFF → grant_oh=0, bus_valid=0, bus_out=0x00, ack=0.
- RR burst cap: mode_rr=1, req=0x08 held, data_in[3]=0xA5 → grant_oh=0x08 at t+1; 4 beats of 0xA5 with ack=0x08 at t+2..t+5; IDLE at t+5; next grant 0x08 at t+7.
- RR fairness/wrap: req=0x81 held → grants alternate ch0, ch7, ch0. After ch7, rr_ptr=0, confirming wrap.
- Early release: grant ch2, drop req[2] after 2 beats → exactly 2 acks, bus_valid=0 next edge, rr_ptr=3.
- Fixed mode: mode_rr=0, sel=5, req=0xFF → only ch5 granted repeatedly. Switch sel to 1 mid-burst → burst on ch5 completes, next grant ch1. Repeat with N_CH=6, sel=7 → no grant.
- Reset mid-burst: rst asserted after beat 2 → next cycle all outputs zero; after release, ch0 is searched first.
